// File: rtl/counter_4bit_pkg.sv
// counter_4bit_pkg: shared constants for the counter_4bit slice
package counter_4bit_pkg;
  localparam int CNT_W_DEF = 4;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/counter_4bit_next.sv
// counter_4bit_next: next-value and terminal-count logic; COUNTER_4BIT_SAT_EN selects saturate vs wrap
module counter_4bit_next
  import counter_4bit_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic [WIDTH-1:0] count,
  input  logic             ud,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);
  logic at_max;
  logic at_min;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  // step in the selected direction; tc marks the value the next step would leave
  always_comb begin
    at_max = count == {WIDTH{1'b1}};
    at_min = count == '0;
    inc = count + WIDTH'(1);
    dec = count - WIDTH'(1);
`ifdef COUNTER_4BIT_SAT_EN
    nxt = ud == DIR_UP ? (at_max ? count : inc) : (at_min ? count : dec);
`else
    nxt = ud == DIR_UP ? inc : dec;
`endif
    tc = ud == DIR_UP ? at_max : at_min;
  end
endmodule

// File: rtl/counter_4bit.sv
// counter_4bit: up/down counter with sync reset; COUNTER_4BIT_SAT_EN saturates instead of wrapping
module counter_4bit
  import counter_4bit_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             ud,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  logic [WIDTH-1:0] nxt;
  counter_4bit_next #(.WIDTH(WIDTH)) u_next (
    .count(count),
    .ud(ud),
    .nxt(nxt),
    .tc(tc)
  );
  // count register; reset wins over stepping
  always_ff @(posedge clk)
    count <= rst ? RST_VAL : nxt;
endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: directed checks of reset, wrap/saturate, direction change and tc (COUNTER_4BIT_SAT_EN aware)
module tb_counter_4bit;
  logic clk = 1'b0;
  logic ud = 1'b1;
  logic rst = 1'b1;
  logic [3:0] count;
  logic tc;
  int vectors = 0;
  int miscompares = 0;
  counter_4bit dut (
    .clk(clk),
    .ud(ud),
    .rst(rst),
    .count(count),
    .tc(tc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic edge_step(input logic u, input logic r);
    ud = u;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int e;
    #1;
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b1, 1'b1);
      chk("rst_count", 16'(count), 16'd0);
      chk("rst_tc", 16'(tc), 16'd0);
    end
`ifndef COUNTER_4BIT_SAT_EN
    for (int i = 0; i < 20; i++) begin
      edge_step(1'b1, 1'b0);
      e = (i + 1) % 16;
      chk("up_count", 16'(count), 16'(e));
      chk("up_tc", 16'(tc), 16'(e == 15));
    end
    chk("up_final", 16'(count), 16'd4);
    for (int i = 0; i < 5; i++) begin
      edge_step(1'b0, 1'b0);
      e = (4 - (i + 1) + 16) % 16;
      chk("dn_count", 16'(count), 16'(e));
      chk("dn_tc", 16'(tc), 16'(e == 0));
    end
    chk("dn_wrap", 16'(count), 16'd15);
    for (int i = 0; i < 10; i++) edge_step(1'b1, 1'b0);
    chk("pre_mid_rst", 16'(count), 16'd9);
    edge_step(1'b1, 1'b1);
    chk("mid_rst_count", 16'(count), 16'd0);
    chk("mid_rst_tc", 16'(tc), 16'd0);
    edge_step(1'b1, 1'b0);
    chk("resume", 16'(count), 16'd1);
    edge_step(1'b0, 1'b1);
    chk("rst_dn_count", 16'(count), 16'd0);
    chk("rst_dn_tc", 16'(tc), 16'd1);
    ud = 1'b1;
    #1;
    chk("tc_comb_up", 16'(tc), 16'd0);
    ud = 1'b0;
    #1;
    chk("tc_comb_dn", 16'(tc), 16'd1);
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b1, 1'b0);
      chk("dir_up", 16'(count), 16'(i + 1));
    end
    edge_step(1'b0, 1'b0);
    chk("dir_dn", 16'(count), 16'd2);
`else
    for (int i = 0; i < 20; i++) begin
      edge_step(1'b1, 1'b0);
      e = i + 1 > 15 ? 15 : i + 1;
      chk("sat_up_count", 16'(count), 16'(e));
      chk("sat_up_tc", 16'(tc), 16'(e == 15));
    end
    for (int i = 0; i < 20; i++) begin
      edge_step(1'b0, 1'b0);
      e = 15 - (i + 1) < 0 ? 0 : 15 - (i + 1);
      chk("sat_dn_count", 16'(count), 16'(e));
      chk("sat_dn_tc", 16'(tc), 16'(e == 0));
    end
    edge_step(1'b1, 1'b0);
    chk("sat_leave_min", 16'(count), 16'd1);
    edge_step(1'b1, 1'b1);
    chk("sat_rst", 16'(count), 16'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/counter_4bit.md
COUNTER_4BIT -- requirements
Module: counter_4bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-003 Parameter RST_VAL, default 0: value loaded into count by reset; must fit in WIDTH bits.
REQ-004 Port order SHALL be clk, ud, rst, count, tc, so that positional instantiation with the first four ports remains valid.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 ud  input  1  direction select; 1 = count up, 0 = count down.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 count  output  WIDTH  registered counter value.
REQ-009 tc  output  1  combinational terminal-count flag.

Function
REQ-010 On every rising clk edge with rst=0 and ud=1, count SHALL become count+1 modulo 2^WIDTH, giving a latency of one cycle.
REQ-011 On every rising clk edge with rst=0 and ud=0, count SHALL become count-1 modulo 2^WIDTH.
REQ-012 Wrap-around SHALL follow these rules when COUNTER_4BIT_SAT_EN is undefined:
- counting up from 2^WIDTH-1 (15) gives 0;
- counting down from 0 gives 2^WIDTH-1 (15).
REQ-013 ud SHALL be sampled only at the rising edge, and a change of ud takes effect at the next edge with no dead cycle.
REQ-014 tc SHALL be 1 when either of these holds, and 0 otherwise:
- ud=1 and count = 2^WIDTH-1;
- ud=0 and count = 0.
REQ-015 tc SHALL be a pure combinational function of count and ud, with no added latency.
REQ-016 count SHALL never be X after the first reset edge, and no other state SHALL exist besides count.

Reset
REQ-017 When rst=1 at a rising clk edge, count SHALL become RST_VAL (0 by default) regardless of ud.
REQ-018 rst SHALL take priority over counting at every edge, including when it is asserted mid-sequence.
REQ-019 count SHALL hold RST_VAL for as long as rst stays high, and the first count step SHALL occur at the first edge where rst=0.
REQ-020 Reset SHALL be purely synchronous, with no asynchronous path from rst to count.
REQ-021 After reset with defaults, tc SHALL read 1 if ud=0 and 0 if ud=1.

Configuration
REQ-022 With macro COUNTER_4BIT_SAT_EN defined, count SHALL saturate instead of wrapping:
- it holds at 2^WIDTH-1 when counting up;
- it holds at 0 when counting down;
- tc behaves as in REQ-014.
REQ-023 With COUNTER_4BIT_SAT_EN undefined, the block SHALL implement the modulo wrap of REQ-012, and the port list SHALL be identical in both builds.

Structure
REQ-024 A shared package counter_4bit_pkg SHALL hold the following, and no typedef SHALL be declared locally in the module:
- the default width constant CNT_W_DEF = 4;
- the direction constants DIR_UP = 1 and DIR_DN = 0.
REQ-025 The next-value and saturation/wrap logic SHALL live in one combinational sub-module, counter_4bit_next, with inputs count and ud and outputs nxt and tc.
REQ-026 The top level SHALL contain only the count register and the reset mux.

Verification
REQ-027 Reset scenario: hold rst=1 for 3 edges with ud=1 -> count=0 after the first edge and stays 0, with tc=0.
REQ-028 Up-count scenario: release rst with ud=1 and run 20 edges -> count runs 1,2,...,15,0,1,...,4; tc=1 exactly while count=15; final count=4.
REQ-029 Down-count scenario: from count=4 set ud=0 and run 5 edges -> count runs 3,2,1,0,15; tc=1 while count=0.
REQ-030 Mid-run reset scenario: at count=9 with ud=1 assert rst for 1 edge -> count=0 at that edge, then counting resumes to 1 on the next edge.
REQ-031 Direction-change scenario: from 0 count up 3 edges then down 1 edge -> count=3 then 2, with no skipped or stalled edge.
REQ-032 Saturation scenario (COUNTER_4BIT_SAT_EN defined): run 20 up edges from 0 -> count stays 15 from the 15th edge on with tc=1; then 20 down edges -> count stays 0.
